rally_controller: RTL and testbench

- Match sequencer for the 16-LED ball datapath.
- Arbitrates the two player buttons into single-cycle hit commands (leftdirection/rightdirection) and issues serve commands.
- Detects missed returns from the ball's light/direction outputs and keeps score.
- Sequences serve → rally → point → game over; sits between the board buttons and the ball block.

---
 rtl/rally_controller.sv | 205 ++++++++++++++++++++
 tb/tb_rally_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rally_controller.sv
// rtl/rally_controller.sv - match sequencer: serve/hit arbitration, miss detection, scoring
// Sits between the board buttons and the ball block; every output is registered.
module rally_controller #(
   parameter int WIN_SCORE    = 11,
   parameter int HIT_WINDOW   = 3,
   parameter int MISS_CYCLES  = 16,
   parameter int POINT_CYCLES = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        left_btn,
   input  logic        right_btn,
   input  logic [15:0] light,
   input  logic [1:0]  direction,
   output logic [1:0]  serve,
   output logic        leftdirection,
   output logic        rightdirection,
   output logic [3:0]  score_left,
   output logic [3:0]  score_right,
   output logic [7:0]  rally_count,
   output logic        game_over,
   output logic [1:0]  winner,
   output logic [2:0]  state
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT      = 3'd1;
   localparam logic [2:0] S_SERVE     = 3'd2;
   localparam logic [2:0] S_RALLY     = 3'd3;
   localparam logic [2:0] S_POINT     = 3'd4;
   localparam logic [2:0] S_GAME_OVER = 3'd5;

   localparam int MW = $clog2(MISS_CYCLES + 1);
   localparam int PW = $clog2(POINT_CYCLES + 1);
   localparam logic [MW-1:0] MISS_MAX = MW'(MISS_CYCLES);
   localparam logic [PW-1:0] PT_LAST  = PW'(POINT_CYCLES - 1);
   localparam logic [3:0]    WIN      = 4'(WIN_SCORE);
   localparam logic [1:0]    DIR_L    = 2'b01;
   localparam logic [1:0]    DIR_R    = 2'b10;

   logic          start_q, left_q, right_q;
   logic          start_edge, left_edge, right_edge;
   logic          server_q, server_d;
   logic          lock_l, lock_r, lock_l_d, lock_r_d;
   logic [MW-1:0] miss_q, miss_d, miss_inc;
   logic [PW-1:0] pt_q, pt_d;
   logic [2:0]    state_d;
   logic [1:0]    serve_d, winner_d;
   logic          ld_d, rd_d, go_d;
   logic [3:0]    sl_d, sr_d;
   logic [7:0]    rc_d;
   logic          left_hit, right_hit, hit, left_miss, miss_cond, miss_fire, win_reached, serve_ok;

   assign start_edge = start & ~start_q;
   assign left_edge  = left_btn & ~left_q;
   assign right_edge = right_btn & ~right_q;

   assign left_hit  = left_edge  && (direction == DIR_L) && (|light[15 -: HIT_WINDOW]) && !lock_l;
   assign right_hit = right_edge && (direction == DIR_R) && (|light[HIT_WINDOW-1:0]) && !lock_r;
   assign hit       = left_hit || right_hit;

   assign left_miss = light[15] && (direction == DIR_L);
   assign miss_cond = left_miss || (light[0] && (direction == DIR_R));
   assign miss_inc  = miss_q + MW'(1);
   // A hit landing on the final miss cycle takes priority over the lost point.
   assign miss_fire = (state == S_RALLY) && miss_cond && !hit && (miss_inc == MISS_MAX);

   assign win_reached = (score_left == WIN) || (score_right == WIN);
   assign serve_ok    = server_q ? right_edge : left_edge;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= S_IDLE;
         start_q        <= 1'b0;
         left_q         <= 1'b0;
         right_q        <= 1'b0;
         server_q       <= 1'b0;
         lock_l         <= 1'b0;
         lock_r         <= 1'b0;
         miss_q         <= '0;
         pt_q           <= '0;
         serve          <= 2'b00;
         leftdirection  <= 1'b0;
         rightdirection <= 1'b0;
         score_left     <= 4'd0;
         score_right    <= 4'd0;
         rally_count    <= 8'd0;
         game_over      <= 1'b0;
         winner         <= 2'b00;
      end else begin
         state          <= state_d;
         start_q        <= start;
         left_q         <= left_btn;
         right_q        <= right_btn;
         server_q       <= server_d;
         lock_l         <= lock_l_d;
         lock_r         <= lock_r_d;
         miss_q         <= miss_d;
         pt_q           <= pt_d;
         serve          <= serve_d;
         leftdirection  <= ld_d;
         rightdirection <= rd_d;
         score_left     <= sl_d;
         score_right    <= sr_d;
         rally_count    <= rc_d;
         game_over      <= go_d;
         winner         <= winner_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:      if (start_edge) state_d = S_WAIT;
         S_WAIT:      if (serve_ok) state_d = S_SERVE;
         S_SERVE:     state_d = S_RALLY;
         S_RALLY:     if (miss_fire) state_d = S_POINT;
         S_POINT:     if (pt_q == PT_LAST) state_d = win_reached ? S_GAME_OVER : S_WAIT;
         S_GAME_OVER: if (start_edge) state_d = S_WAIT;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      serve_d  = 2'b00;
      ld_d     = 1'b0;
      rd_d     = 1'b0;
      sl_d     = score_left;
      sr_d     = score_right;
      rc_d     = rally_count;
      go_d     = game_over;
      winner_d = winner;
      server_d = server_q;
      miss_d   = miss_q;
      pt_d     = pt_q;
      lock_l_d = lock_l && (direction == DIR_L);
      lock_r_d = lock_r && (direction == DIR_R);
      case (state)
         S_IDLE: begin
            if (start_edge) begin
               sl_d     = 4'd0;
               sr_d     = 4'd0;
               rc_d     = 8'd0;
               server_d = 1'b0;
            end
         end
         S_WAIT: begin
            if (serve_ok) serve_d = server_q ? 2'b10 : 2'b01;
         end
         S_SERVE: begin
            rc_d     = 8'd0;
            miss_d   = '0;
            lock_l_d = 1'b0;
            lock_r_d = 1'b0;
         end
         S_RALLY: begin
            if (hit) begin
               ld_d     = left_hit;
               rd_d     = right_hit;
               lock_l_d = lock_l_d || left_hit;
               lock_r_d = lock_r_d || right_hit;
               rc_d     = (rally_count == 8'hFF) ? rally_count : rally_count + 8'd1;
               miss_d   = '0;
            end else if (miss_fire) begin
               miss_d = '0;
               pt_d   = '0;
               if (left_miss) begin
                  sr_d     = (score_right < WIN) ? score_right + 4'd1 : score_right;
                  server_d = 1'b1;
               end else begin
                  sl_d     = (score_left < WIN) ? score_left + 4'd1 : score_left;
                  server_d = 1'b0;
               end
            end else if (miss_cond) begin
               miss_d = miss_inc;
            end else begin
               miss_d = '0;
            end
         end
         S_POINT: begin
            if (pt_q == PT_LAST) begin
               pt_d = '0;
               if (win_reached) begin
                  go_d     = 1'b1;
                  winner_d = (score_left == WIN) ? 2'b01 : 2'b10;
               end
            end else begin
               pt_d = pt_q + PW'(1);
            end
         end
         S_GAME_OVER: begin
            if (start_edge) begin
               sl_d     = 4'd0;
               sr_d     = 4'd0;
               go_d     = 1'b0;
               winner_d = 2'b00;
               server_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rally_controller.sv
// tb/tb_rally_controller.sv - directed bench for rally_controller
module tb_rally_controller;

   logic        clock = 1'b0;
   logic        reset, start, left_btn, right_btn;
   logic [15:0] light;
   logic [1:0]  direction;
   logic [1:0]  serve, winner;
   logic        leftdirection, rightdirection, game_over;
   logic [3:0]  score_left, score_right;
   logic [7:0]  rally_count;
   logic [2:0]  state;
   int checks = 0;
   int failures = 0;

   rally_controller dut (
      .clock(clock), .reset(reset), .start(start), .left_btn(left_btn), .right_btn(right_btn),
      .light(light), .direction(direction), .serve(serve), .leftdirection(leftdirection),
      .rightdirection(rightdirection), .score_left(score_left), .score_right(score_right),
      .rally_count(rally_count), .game_over(game_over), .winner(winner), .state(state)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; left_btn = 1'b0; right_btn = 1'b0;
      light = 16'h0000; direction = 2'b00;
      tick(); tick();
      checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
      checks++; if ({serve, leftdirection, rightdirection, score_left, score_right, rally_count, game_over, winner} !== 25'd0) begin
         failures++; $display("FAIL reset_outputs got=%h exp=0", {serve, leftdirection, rightdirection, score_left, score_right, rally_count, game_over, winner}); end
      reset = 1'b1;
      tick();
      checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_hold got=%0d exp=0", state); end
      start = 1'b1;
      tick();
      checks++; if (state !== 3'd1) begin failures++; $display("FAIL start_to_wait got=%0d exp=1", state); end
      checks++; if ({score_left, score_right} !== 8'h00) begin failures++; $display("FAIL start_scores got=%h exp=00", {score_left, score_right}); end
      start = 1'b0;
      tick();
   endtask

   task automatic test_serve();
      right_btn = 1'b1;
      tick();
      checks++; if (serve !== 2'b00 || state !== 3'd1) begin failures++; $display("FAIL nonserver_ignored serve=%b state=%0d exp serve=00 state=1", serve, state); end
      right_btn = 1'b0;
      tick();
      left_btn = 1'b1;
      tick();
      checks++; if (serve !== 2'b01 || state !== 3'd2) begin failures++; $display("FAIL serve_pulse serve=%b state=%0d exp serve=01 state=2", serve, state); end
      left_btn = 1'b0;
      tick();
      checks++; if (serve !== 2'b00 || state !== 3'd3) begin failures++; $display("FAIL serve_end serve=%b state=%0d exp serve=00 state=3", serve, state); end
   endtask

   task automatic test_valid_hit();
      direction = 2'b01; light = 16'h8000; left_btn = 1'b1;
      tick();
      checks++; if (leftdirection !== 1'b1 || rally_count !== 8'd1) begin failures++; $display("FAIL left_hit ld=%b rally=%0d exp ld=1 rally=1", leftdirection, rally_count); end
      left_btn = 1'b0;
      tick();
      checks++; if (leftdirection !== 1'b0) begin failures++; $display("FAIL hit_pulse_width got=%b exp=0", leftdirection); end
      left_btn = 1'b1;
      tick();
      checks++; if (leftdirection !== 1'b0 || rally_count !== 8'd1) begin failures++; $display("FAIL lock_ignored ld=%b rally=%0d exp ld=0 rally=1", leftdirection, rally_count); end
      left_btn = 1'b0; direction = 2'b10; light = 16'h0000;
      tick();
      direction = 2'b01; light = 16'h0100; left_btn = 1'b1;
      tick();
      checks++; if (leftdirection !== 1'b0 || rally_count !== 8'd1) begin failures++; $display("FAIL out_of_window ld=%b rally=%0d exp ld=0 rally=1", leftdirection, rally_count); end
      left_btn = 1'b0; direction = 2'b00; light = 16'h0000;
      tick();
   endtask

   task automatic test_miss();
      direction = 2'b10; light = 16'h0001;
      repeat (15) tick();
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL miss_early got=%0d exp=3", state); end
      tick();
      checks++; if (state !== 3'd4 || score_left !== 4'd1 || score_right !== 4'd0) begin
         failures++; $display("FAIL miss_point state=%0d L=%0d R=%0d exp state=4 L=1 R=0", state, score_left, score_right); end
      direction = 2'b00; light = 16'h0000;
      repeat (31) tick();
      checks++; if (state !== 3'd4 || rally_count !== 8'd1) begin failures++; $display("FAIL point_hold state=%0d rally=%0d exp state=4 rally=1", state, rally_count); end
      tick();
      checks++; if (state !== 3'd1) begin failures++; $display("FAIL point_end got=%0d exp=1", state); end
      right_btn = 1'b1;
      tick();
      checks++; if (serve !== 2'b00 || state !== 3'd1) begin failures++; $display("FAIL server_left_only serve=%b state=%0d exp serve=00 state=1", serve, state); end
      right_btn = 1'b0; left_btn = 1'b1;
      tick();
      checks++; if (serve !== 2'b01) begin failures++; $display("FAIL next_serve_left got=%b exp=01", serve); end
      left_btn = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous();
      direction = 2'b01; light = 16'h4000; left_btn = 1'b1; right_btn = 1'b1;
      tick();
      checks++; if (leftdirection !== 1'b1 || rightdirection !== 1'b0 || rally_count !== 8'd1) begin
         failures++; $display("FAIL simultaneous ld=%b rd=%b rally=%0d exp ld=1 rd=0 rally=1", leftdirection, rightdirection, rally_count); end
      left_btn = 1'b0; right_btn = 1'b0;
      tick();
      direction = 2'b10; light = 16'h0002; right_btn = 1'b1;
      tick();
      checks++; if (rightdirection !== 1'b1 || leftdirection !== 1'b0 || rally_count !== 8'd2) begin
         failures++; $display("FAIL right_hit rd=%b ld=%b rally=%0d exp rd=1 ld=0 rally=2", rightdirection, leftdirection, rally_count); end
      right_btn = 1'b0; light = 16'h0000;
      tick();
   endtask

   task automatic test_hit_on_last_miss_cycle();
      direction = 2'b01; light = 16'h8000;
      repeat (15) tick();
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL boundary_pre got=%0d exp=3", state); end
      left_btn = 1'b1;
      tick();
      checks++; if (leftdirection !== 1'b1 || state !== 3'd3 || score_right !== 4'd0 || rally_count !== 8'd3) begin
         failures++; $display("FAIL hit_beats_miss ld=%b state=%0d R=%0d rally=%0d exp ld=1 state=3 R=0 rally=3", leftdirection, state, score_right, rally_count); end
      left_btn = 1'b0; direction = 2'b00; light = 16'h0000;
      tick();
   endtask

   task automatic test_game_over();
      for (int p = 2; p <= 11; p++) begin
         if (p > 2) begin
            left_btn = 1'b1; tick();
            left_btn = 1'b0; tick();
         end
         direction = 2'b10; light = 16'h0001;
         repeat (16) tick();
         direction = 2'b00; light = 16'h0000;
         repeat (32) tick();
      end
      checks++; if (state !== 3'd5 || game_over !== 1'b1 || winner !== 2'b01) begin
         failures++; $display("FAIL game_over state=%0d go=%b win=%b exp state=5 go=1 win=01", state, game_over, winner); end
      checks++; if (score_left !== 4'd11 || score_right !== 4'd0) begin
         failures++; $display("FAIL final_score L=%0d R=%0d exp L=11 R=0", score_left, score_right); end
      start = 1'b1;
      tick();
      checks++; if (state !== 3'd1 || {score_left, score_right} !== 8'h00 || game_over !== 1'b0 || winner !== 2'b00) begin
         failures++; $display("FAIL restart state=%0d scores=%h go=%b win=%b exp state=1 scores=00 go=0 win=00", state, {score_left, score_right}, game_over, winner); end
      start = 1'b0;
      tick();
   endtask

   task automatic test_reset_in_point();
      left_btn = 1'b1; tick();
      left_btn = 1'b0; tick();
      direction = 2'b10; light = 16'h0001;
      repeat (16) tick();
      direction = 2'b00; light = 16'h0000;
      repeat (5) tick();
      checks++; if (state !== 3'd4 || score_left !== 4'd1) begin failures++; $display("FAIL pre_reset state=%0d L=%0d exp state=4 L=1", state, score_left); end
      reset = 1'b0;
      tick();
      checks++; if (state !== 3'd0) begin failures++; $display("FAIL midgame_reset_state got=%0d exp=0", state); end
      checks++; if ({serve, leftdirection, rightdirection, score_left, score_right, rally_count, game_over, winner} !== 25'd0) begin
         failures++; $display("FAIL midgame_reset_outputs got=%h exp=0", {serve, leftdirection, rightdirection, score_left, score_right, rally_count, game_over, winner}); end
      reset = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_serve();
      test_valid_hit();
      test_miss();
      test_simultaneous();
      test_hit_on_last_miss_cycle();
      test_game_over();
      test_reset_in_point();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
